imm_gen_pipe: RTL and testbench

- Registered, parametrised immediate generator for the decode stage.
- Extracts and sign-/zero-extends the immediate for every RV32I/RV64I format, classifies the format, and precomputes pc+imm for PC-relative instructions.
- Sits between fetch and the register-read/execute stage, with a valid/ready handshake on both sides.
- Includes an optional 2-entry skid buffer and a pipeline flush.

---
 rtl/imm_gen_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extracts and extends the RV32I/RV64I immediate,
// classifies its format and precomputes pc+imm, behind a valid/ready pipeline register.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSRZ  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
  } entry_t;

  logic [XLEN-1:0] imm_s;
  fmt_e            fmt_s;
  logic            pcrel_s;
  logic            is_shift_s;
  entry_t          in_ent_s;

  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       push_s, pop_s;

  assign is_shift_s = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);

  // Immediate extraction, format classification and the pc-relative adder
  always_comb begin
    imm_s   = '0;
    fmt_s   = FMT_NONE;
    pcrel_s = 1'b0;
    case (in_instr[6:0])
      OP_LOAD, OP_JALR: begin
        fmt_s = FMT_I;
        imm_s = XLEN'($signed(in_instr[31:20]));
      end
      OP_IMM: begin
        if (is_shift_s) begin
          fmt_s = FMT_SHAMT;
          if (XLEN == 64) begin
            imm_s = XLEN'(in_instr[25:20]);
          end else begin
            imm_s = XLEN'(in_instr[24:20]);
          end
        end else begin
          fmt_s = FMT_I;
          imm_s = XLEN'($signed(in_instr[31:20]));
        end
      end
      OP_IMM32: begin
        if (XLEN != 64) begin
          fmt_s = FMT_NONE;
        end else if (is_shift_s) begin
          fmt_s = FMT_SHAMT;
          imm_s = XLEN'(in_instr[24:20]);
        end else begin
          fmt_s = FMT_I;
          imm_s = XLEN'($signed(in_instr[31:20]));
        end
      end
      OP_STORE: begin
        fmt_s = FMT_S;
        imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        fmt_s   = FMT_B;
        pcrel_s = 1'b1;
        imm_s   = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OP_JAL: begin
        fmt_s   = FMT_J;
        pcrel_s = 1'b1;
        imm_s   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt_s   = FMT_U;
        pcrel_s = (in_instr[6:0] == OP_AUIPC);
        imm_s   = XLEN'($signed({in_instr[31:12], 12'h000}));
      end
      OP_SYSTEM: begin
        if (in_instr[14] && (in_instr[13:12] != 2'b00)) begin
          fmt_s = FMT_CSRZ;
          imm_s = XLEN'(in_instr[19:15]);
        end else begin
          fmt_s = FMT_NONE;
        end
      end
      default: begin
        fmt_s = FMT_NONE;
      end
    endcase
    in_ent_s.instr  = in_instr;
    in_ent_s.pc     = in_pc;
    in_ent_s.imm    = imm_s;
    in_ent_s.fmt    = fmt_s;
    in_ent_s.target = pcrel_s ? (in_pc + imm_s) : '0;
  end

  // With SKID=0 the single slot frees up whenever downstream drains it this cycle
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready;

  // Two-slot queue update; slot0 always feeds the outputs, slot1 is the skid entry
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = in_ent_s;
          end else begin
            slot1_d = in_ent_s;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = in_ent_s;
          end else begin
            slot0_d = in_ent_s;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    in_ready_d = (count_d != 2'd2);
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_instr  = slot0_q.instr;
  assign out_pc     = slot0_q.pc;
  assign out_imm    = slot0_q.imm;
  assign out_fmt    = slot0_q.fmt;
  assign out_target = slot0_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: three instances (32/skid, 64/skid, 32/no-skid)
// share stimulus; each has its own expected-entry queue filled from a reference model.
module tb_imm_gen_pipe;

  typedef logic [226:0] ent_t; // {instr 32, pc 64, imm 64, fmt 3, target 64}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [63:0] in_pc = 64'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_e(input string name, input ent_t act, input ent_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: immediates rebuilt with signed integer arithmetic
  function automatic ent_t model(input logic [31:0] ins, input logic [63:0] pc, input int xl);
    logic [63:0] mask;
    logic [63:0] immv;
    logic [63:0] tgt;
    longint      wide;
    int          sx;
    int          v;
    int          fmt;
    bit          pcrel;
    bit          shift;
    mask  = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    sx    = ins;
    v     = 0;
    fmt   = 0;
    pcrel = 1'b0;
    shift = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    case (ins[6:0])
      7'h03, 7'h67: begin fmt = 1; v = sx >>> 20; end
      7'h13: begin
        if (shift) begin
          fmt = 6;
          v = (xl == 64) ? int'(ins[25:20]) : int'(ins[24:20]);
        end else begin
          fmt = 1; v = sx >>> 20;
        end
      end
      7'h1B: begin
        if (xl == 64) begin
          if (shift) begin fmt = 6; v = int'(ins[24:20]); end
          else begin fmt = 1; v = sx >>> 20; end
        end
      end
      7'h23: begin fmt = 2; v = (sx >>> 25) * 32 + int'(ins[11:7]); end
      7'h63: begin
        fmt = 3; pcrel = 1'b1;
        v = (sx >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      7'h6F: begin
        fmt = 5; pcrel = 1'b1;
        v = (sx >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
      end
      7'h37: begin fmt = 4; v = (sx >>> 12) * 4096; end
      7'h17: begin fmt = 4; pcrel = 1'b1; v = (sx >>> 12) * 4096; end
      7'h73: begin
        if (int'(ins[14:12]) >= 5) begin fmt = 7; v = int'(ins[19:15]); end
      end
      default: fmt = 0;
    endcase
    wide = v;
    immv = 64'(wide) & mask;
    tgt  = pcrel ? (((pc & mask) + immv) & mask) : 64'd0;
    return {ins, pc & mask, immv, 3'(fmt), tgt};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL = (g == 1) ? 64 : 32;
    localparam int SK = (g == 2) ? 0 : 1;
    logic          ir, ov;
    logic [31:0]   oi;
    logic [XL-1:0] op, om, ot;
    logic [2:0]    of;
    ent_t          act, prev;
    ent_t          q[$];
    logic          stall = 1'b0;
    int            pops = 0;

    imm_gen_pipe #(.XLEN(XL), .SKID(SK)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(ir), .in_instr(in_instr), .in_pc(in_pc[XL-1:0]),
      .out_valid(ov), .out_ready(out_ready), .out_instr(oi), .out_pc(op),
      .out_imm(om), .out_fmt(of), .out_target(ot)
    );

    assign act = {oi, 64'(op), 64'(om), of, 64'(ot)};

    // Monitor: checks handshake state, stability and popped entries on the falling edge
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        stall = 1'b0;
      end else begin
        chk($sformatf("dut%0d out_valid", g), 64'(ov), 64'(q.size() != 0));
        if (SK != 0) chk($sformatf("dut%0d in_ready", g), 64'(ir), 64'(q.size() != 2));
        else chk($sformatf("dut%0d in_ready", g), 64'(ir), 64'((q.size() == 0) || out_ready));
        if (stall) chk_e($sformatf("dut%0d hold", g), act, prev);
        if (ov && out_ready && !flush && (q.size() != 0)) begin
          chk_e($sformatf("dut%0d entry", g), act, q.pop_front());
          pops++;
        end
        if (flush) q.delete();
        else if (in_valid && ir) q.push_back(model(in_instr, in_pc, XL));
        prev  = act;
        stall = ov && !out_ready && !flush;
      end
    end
  end

  logic [31:0] opcodes [12] = '{32'h03, 32'h67, 32'h13, 32'h1B, 32'h23, 32'h63,
                                32'h6F, 32'h37, 32'h17, 32'h73, 32'h33, 32'h7F};

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  int p0;
  bit acc;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(g_dut[0].ov), 64'd0);
    chk("rst out_instr", 64'(g_dut[0].oi), 64'd0);
    chk("rst out_pc", 64'(g_dut[1].op), 64'd0);
    chk("rst out_imm", 64'(g_dut[1].om), 64'd0);
    chk("rst out_fmt", 64'(g_dut[0].of), 64'd0);
    chk("rst out_target", 64'(g_dut[1].ot), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed decode vectors
    send(32'hFFF00093, 64'h100);
    chk("addi valid", 64'(g_dut[0].ov), 64'd1);
    chk("addi imm", 64'(g_dut[0].om), 64'hFFFF_FFFF);
    chk("addi fmt", 64'(g_dut[0].of), 64'd1);
    chk("addi target", 64'(g_dut[0].ot), 64'd0);
    send(32'hFE000EE3, 64'h200);
    chk("beq imm", 64'(g_dut[0].om), 64'hFFFF_FFFC);
    chk("beq fmt", 64'(g_dut[0].of), 64'd3);
    chk("beq target", 64'(g_dut[0].ot), 64'h1FC);
    chk("beq target64", 64'(g_dut[1].ot), 64'h1FC);
    send(32'hFE000EE3, 64'h0);
    chk("beq wrap32", 64'(g_dut[0].ot), 64'hFFFF_FFFC);
    chk("beq wrap64", 64'(g_dut[1].ot), 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'h03F09093, 64'h0);
    chk("slli64 imm", 64'(g_dut[1].om), 64'd63);
    chk("slli64 fmt", 64'(g_dut[1].of), 64'd6);
    chk("slli32 imm", 64'(g_dut[0].om), 64'd31);
    send(32'h800000B7, 64'h40);
    chk("lui64 imm", 64'(g_dut[1].om), 64'hFFFF_FFFF_8000_0000);
    chk("lui64 fmt", 64'(g_dut[1].of), 64'd4);
    chk("lui target", 64'(g_dut[1].ot), 64'd0);
    send(32'h300FD073, 64'h0);
    chk("csrrwi imm", 64'(g_dut[0].om), 64'd31);
    chk("csrrwi fmt", 64'(g_dut[0].of), 64'd7);
    send(32'h0000007F, 64'h0);
    chk("none fmt", 64'(g_dut[0].of), 64'd0);
    chk("none imm", 64'(g_dut[0].om), 64'd0);

    // Skid buffer: three back-to-back entries against a stalled sink
    cyc();
    out_ready = 1'b0;
    p0 = g_dut[0].pops;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h1000;
    cyc(); in_instr = 32'h00200113; in_pc = 64'h1004;
    cyc(); in_instr = 32'h0000006F; in_pc = 64'h1008;
    repeat (4) begin
      @(negedge clk);
      chk("skid full in_ready", 64'(g_dut[0].ir), 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = g_dut[0].ir;
      cyc();
    end
    chk("skid third accepted", 64'(acc), 64'd1);
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("skid drained count", 64'(g_dut[0].pops - p0), 64'd3);

    // Flush with two entries buffered and a live input offered
    out_ready = 1'b0;
    p0 = g_dut[0].pops;
    in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 64'h2000;
    cyc(); in_instr = 32'h00600313; in_pc = 64'h2004;
    cyc(); in_instr = 32'h00700393; in_pc = 64'h2008; flush = 1'b1;
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 64'(g_dut[0].ov), 64'd0);
    chk("flush in_ready", 64'(g_dut[0].ir), 64'd1);
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("flush nothing emitted", 64'(g_dut[0].pops - p0), 64'd0);

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000517; in_pc = 64'h3000;
    repeat (2) cyc();
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 1; k++) begin
      chk("async rst dut0", 64'(g_dut[0].ov), 64'd0);
      chk("async rst dut1", 64'(g_dut[1].ov), 64'd0);
      chk("async rst dut2", 64'(g_dut[2].ov), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      cyc();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_instr[6:0] = opcodes[$urandom_range(0, 11)][6:0];
      in_pc     = {$urandom, $urandom};
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    cyc();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();
    chk("final q0 empty", 64'(g_dut[0].q.size()), 64'd0);
    chk("final q1 empty", 64'(g_dut[1].q.size()), 64'd0);
    chk("final q2 empty", 64'(g_dut[2].q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
